// File: rtl/alloc_rr.sv
// alloc_rr: per-output-port allocator for the phit-switched router.
// Grants one HEAD-requesting input, holds it until TAIL; macro ALLOC_RR_EN.
//
// Ports:
//   clk, rst_n  clock; async active-low reset
//   this_port   id of this output port
//   hdr         top 2+PORT_W bits of each input phit (input i at i*(2+PORT_W))
//   out_ready   downstream can accept a new packet
//   select      one-hot mux select (zero = no phit forwarded)
//   shift       route shifter strobe, head phit only
//   busy        output held by a packet
//   owner       binary index of holder (valid when busy)
//   err         one-cycle pulse on holder protocol error
//
// ALLOC_RR_EN defined: round-robin arbitration; undefined: fixed priority.
module alloc_rr #(
    parameter int N_IN   = 4,
    parameter int PORT_W = 2,
    parameter int IDX_W  = $clog2(N_IN)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORT_W-1:0]           this_port,
    input  logic [N_IN*(2+PORT_W)-1:0]  hdr,
    input  logic                        out_ready,
    output logic [N_IN-1:0]             select,
    output logic                        shift,
    output logic                        busy,
    output logic [IDX_W-1:0]            owner,
    output logic                        err
);

    localparam int HW = 2 + PORT_W;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] owner_q, owner_d;
    logic            err_q, err_d;
    logic [N_IN-1:0] is_head, is_pay, is_tail;
    logic [N_IN-1:0] req, grant;
    logic [N_IN-1:0] sel_c;
    logic            shift_c;
    logic            h_head, h_pay, h_tail;

    always_comb begin
        is_head = '0;
        is_pay  = '0;
        is_tail = '0;
        req     = '0;
        for (int i = 0; i < N_IN; i++) begin
            is_head[i] = hdr[i*HW+PORT_W +: 2] == 2'b11;
            is_pay[i]  = hdr[i*HW+PORT_W +: 2] == 2'b10;
            is_tail[i] = hdr[i*HW+PORT_W +: 2] == 2'b01;
            req[i]     = is_head[i]
                       && (hdr[i*HW +: PORT_W] == this_port);
        end
    end

    // holder's phit type; owner_q is one-hot in BUSY
    assign h_head = |(is_head & owner_q);
    assign h_pay  = |(is_pay & owner_q);
    assign h_tail = |(is_tail & owner_q);

`ifdef ALLOC_RR_EN
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;

    // search starts at rr_q and wraps modulo N_IN
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_IN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_IN) idx = idx - N_IN;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (state_q == S_IDLE && out_ready && |req) begin
            if (win == IDX_W'(N_IN - 1)) rr_d = '0;
            else                         rr_d = win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end
`else
    logic found;

    // lowest index wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        err_d   = 1'b0;
        sel_c   = '0;
        shift_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (out_ready && |req) begin
                    sel_c   = grant;
                    shift_c = 1'b1;
                    owner_d = grant;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                unique case (1'b1)
                    h_pay: sel_c = owner_q;
                    h_tail: begin
                        sel_c   = owner_q;
                        owner_d = '0;
                        state_d = S_IDLE;
                    end
                    h_head: begin
                        owner_d = '0;
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        owner = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (owner_q[i]) owner = IDX_W'(i);
        end
    end

    // mux controls must be quiet while reset is held
    assign select = sel_c & {N_IN{rst_n}};
    assign shift  = shift_c & rst_n;
    assign busy   = state_q == S_BUSY;
    assign err    = err_q;

endmodule

// File: tb/tb_alloc_rr.sv
// tb_alloc_rr: directed scoreboard bench for alloc_rr.
// N_IN=4, PORT_W=2, this_port=2; honours ALLOC_RR_EN.
module tb_alloc_rr;

    localparam logic [3:0] IDL = 4'b0000;
    localparam logic [3:0] H2  = 4'b1110;
    localparam logic [3:0] H1  = 4'b1101;
    localparam logic [3:0] P2  = 4'b1000;
    localparam logic [3:0] TL  = 4'b0100;

    logic        clk;
    logic        rst_n;
    logic [1:0]  this_port;
    logic [15:0] hdr;
    logic        out_ready;
    logic [3:0]  select;
    logic        shift;
    logic        busy;
    logic [1:0]  owner;
    logic        err;

    typedef struct {
        logic [3:0] sel;
        logic       sh;
        logic       bsy;
        logic [1:0] own;
        logic       er;
    } exp_t;

    exp_t q[$];
    int   n_run;
    int   n_fail;
    int   n_step;

    alloc_rr #(.N_IN(4), .PORT_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .this_port(this_port),
        .hdr      (hdr),
        .out_ready(out_ready),
        .select   (select),
        .shift    (shift),
        .busy     (busy),
        .owner    (owner),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h want %0h",
                     tag, n_step, got, want);
        end
    endtask

    // drive one cycle, queue expectation, check #1 later
    task automatic step(input logic [15:0] h,
                        input logic       rdy,
                        input logic [3:0] es,
                        input logic       esh,
                        input logic       eb,
                        input logic [1:0] eo,
                        input logic       ee);
        exp_t e;
        @(negedge clk);
        n_step++;
        hdr       = h;
        out_ready = rdy;
        q.push_back('{sel: es, sh: esh, bsy: eb, own: eo, er: ee});
        #1;
        e = q.pop_front();
        chk("select", 32'(select), 32'(e.sel));
        chk("shift", 32'(shift), 32'(e.sh));
        chk("busy", 32'(busy), 32'(e.bsy));
        chk("err", 32'(err), 32'(e.er));
        if (e.bsy) chk("owner", 32'(owner), 32'(e.own));
    endtask

    task automatic do_reset();
        @(negedge clk);
        hdr   = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [3:0] w2;
    logic [1:0] wo;

    initial begin
        n_run     = 0;
        n_fail    = 0;
        n_step    = 0;
        this_port = 2'd2;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        hdr       = {IDL, IDL, H2, IDL};
`ifdef ALLOC_RR_EN
        w2 = 4'b1000;
        wo = 2'd3;
`else
        w2 = 4'b0001;
        wo = 2'd0;
`endif
        #3;
        chk("rst_select", 32'(select), 32'd0);
        chk("rst_shift", 32'(shift), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        hdr   = '0;
        rst_n = 1'b1;

        // single packet on input 1
        step({IDL, IDL, IDL, IDL}, 1, 4'b0000, 0, 0, 0, 0);
        step({IDL, IDL, H2, IDL}, 1, 4'b0010, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step({IDL, IDL, P2, IDL}, 1, 4'b0010, 0, 1, 1, 0);
        step({IDL, IDL, TL, IDL}, 1, 4'b0010, 0, 1, 1, 0);
        step({IDL, IDL, IDL, IDL}, 1, 4'b0000, 0, 0, 0, 0);

        // contention between inputs 0 and 3
        do_reset();
        step({H2, IDL, IDL, H2}, 1, 4'b0001, 1, 0, 0, 0);
        step({H2, IDL, IDL, TL}, 1, 4'b0001, 0, 1, 0, 0);
        step({H2, IDL, IDL, H2}, 1, w2, 1, 0, 0, 0);
        if (wo == 2'd3)
            step({TL, IDL, IDL, H2}, 1, w2, 0, 1, wo, 0);
        else
            step({H2, IDL, IDL, TL}, 1, w2, 0, 1, wo, 0);
        step({IDL, IDL, IDL, IDL}, 1, 4'b0000, 0, 0, 0, 0);

        // out_ready gating
        for (int i = 0; i < 3; i++)
            step({IDL, H2, IDL, IDL}, 0, 4'b0000, 0, 0, 0, 0);
        step({IDL, H2, IDL, IDL}, 1, 4'b0100, 1, 0, 0, 0);
        step({IDL, TL, IDL, IDL}, 0, 4'b0100, 0, 1, 2, 0);
        step({IDL, IDL, IDL, IDL}, 1, 4'b0000, 0, 0, 0, 0);

        // bubble, then head from holder
        step({IDL, IDL, IDL, H2}, 1, 4'b0001, 1, 0, 0, 0);
        step({IDL, IDL, IDL, IDL}, 1, 4'b0000, 0, 1, 0, 0);
        step({IDL, IDL, IDL, P2}, 1, 4'b0001, 0, 1, 0, 0);
        step({IDL, IDL, IDL, H2}, 1, 4'b0000, 0, 1, 0, 0);
        step({IDL, IDL, IDL, H2}, 1, 4'b0001, 1, 0, 0, 1);
        step({IDL, IDL, IDL, TL}, 1, 4'b0001, 0, 1, 0, 0);
        step({IDL, IDL, IDL, IDL}, 1, 4'b0000, 0, 0, 0, 0);

        // async reset mid-packet
        step({IDL, IDL, H2, IDL}, 1, 4'b0010, 1, 0, 0, 0);
        step({IDL, IDL, P2, IDL}, 1, 4'b0010, 0, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_select", 32'(select), 32'd0);
        chk("mid_rst_shift", 32'(shift), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_owner", 32'(owner), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step({IDL, H2, IDL, IDL}, 1, 4'b0100, 1, 0, 0, 0);
        step({IDL, TL, IDL, IDL}, 1, 4'b0100, 0, 1, 2, 0);

        // heads routed elsewhere
        step({H1, H1, H1, H1}, 1, 4'b0000, 0, 0, 0, 0);
        step({H1, H1, H1, H1}, 1, 4'b0000, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
